// File: rtl/sb_data_encoder_fifo.sv
// ---------------------------------------------------------------------------
// sb_data_encoder_fifo
//
// Sideband TX data encoder with an output payload FIFO. A message context
// (state / sub-state / message number / test mode) plus a raw data bus is
// mapped combinationally onto a 64-bit payload and a push request. Payloads
// are queued in a FIFO and handed to packet framing through a valid/ready
// handshake. Dropped payloads (push while full, no pop) set a sticky flag.
//
// Optional build feature:
//   SB_ENC_DROP_CNT_EN  adds o_drop_cnt, a saturating 8-bit dropped-payload
//                       counter (cleared by i_ovf_clr, unaffected by flush).
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_msg_valid             single-cycle message request strobe
//   i_data_valid            i_data_bus carries data for this message
//   i_state, i_sub_state    LTSM state / sub-state
//   i_msg_no                message number (0 = idle)
//   i_data_bus              raw data
//   i_test_en, i_test_mode  point-test / eye-sweep context
//   i_flush                 synchronous FIFO clear
//   i_ovf_clr               clears o_overflow (and o_drop_cnt)
//   i_ready                 framing accepts the head payload
//   o_data_encoded          head payload, zero when empty
//   o_d_valid               FIFO non-empty
//   o_level                 occupancy
//   o_overflow              sticky dropped-payload flag
//   o_drop_cnt              (SB_ENC_DROP_CNT_EN only) dropped-payload count
// ---------------------------------------------------------------------------
module sb_data_encoder_fifo #(
  parameter int DATA_W     = 16,
  parameter int PARAM_W    = 11,
  parameter int FIFO_DEPTH = 4,
  parameter int MSG_NO_W   = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_msg_valid,
  input  logic                            i_data_valid,
  input  logic [3:0]                      i_state,
  input  logic [3:0]                      i_sub_state,
  input  logic [MSG_NO_W-1:0]             i_msg_no,
  input  logic [DATA_W-1:0]               i_data_bus,
  input  logic                            i_test_en,
  input  logic [1:0]                      i_test_mode,
  input  logic                            i_flush,
  input  logic                            i_ovf_clr,
  input  logic                            i_ready,
  output logic [63:0]                     o_data_encoded,
  output logic                            o_d_valid,
  output logic [$clog2(FIFO_DEPTH):0]     o_level,
  output logic                            o_overflow
`ifdef SB_ENC_DROP_CNT_EN
  ,
  output logic [7:0]                      o_drop_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [3:0] ST_MBINIT     = 4'd3;
  localparam logic [3:0] SUB_PARAM     = 4'd0;
  localparam logic [3:0] SUB_REVERSAL  = 4'd4;
  localparam logic [1:0] MODE_TX_POINT = 2'd0;
  localparam logic [1:0] MODE_TX_EYE   = 2'd1;
  localparam logic [1:0] MODE_RX_POINT = 2'd2;
  localparam logic [1:0] MODE_RX_EYE   = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Encoder: combinational push request and payload from this cycle's inputs
  logic        enc_push;
  logic [63:0] enc_payload;
  logic [63:0] data_ext;
  logic [63:0] param_ext;

  assign data_ext  = 64'(i_data_bus);
  assign param_ext = 64'(i_data_bus[PARAM_W-1:0]);

  always_comb begin
    enc_push    = 1'b0;
    enc_payload = '0;
    if (i_msg_valid) begin
      if (!i_data_valid) begin
        enc_push = 1'b1;
      end else if (i_test_en) begin
        enc_push = 1'b1;
        if (i_msg_no == MSG_NO_W'(1)) begin
          enc_payload[0]     = i_data_bus[0];
          enc_payload[7:6]   = i_data_bus[2:1];
          enc_payload[11]    = i_data_bus[3];
          enc_payload[58:43] = '1;
          enc_payload[59]    = i_data_bus[4];
        end else if (((i_test_mode == MODE_TX_POINT || i_test_mode == MODE_RX_POINT) &&
                      i_msg_no == MSG_NO_W'(6)) ||
                     (i_test_mode == MODE_RX_EYE && i_msg_no == MSG_NO_W'(9))) begin
          enc_payload = data_ext;
        end else if (i_test_mode == MODE_TX_EYE) begin
          enc_payload = '0;
        end
      end else if (i_msg_no != '0 && i_state == ST_MBINIT) begin
        if (i_sub_state == SUB_PARAM) begin
          enc_push    = 1'b1;
          enc_payload = param_ext;
        end else if (i_sub_state == SUB_REVERSAL && i_msg_no == MSG_NO_W'(6)) begin
          enc_push    = 1'b1;
          enc_payload = data_ext;
        end
      end
    end
  end

  // FIFO control
  logic [63:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full, empty, pop, wr_en, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == LVL_W'(FIFO_DEPTH));
  assign pop   = !empty && i_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = enc_push && (!full || pop) && !i_flush;
  // Flush discards a pending push outright, so it never counts as a drop.
  assign drop  = enc_push && full && !pop && !i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_en && !pop)      count_d = count_q + LVL_W'(1);
      else if (!wr_en && pop) count_d = count_q - LVL_W'(1);
    end
    // A drop in the same cycle as a clear leaves the flag set.
    ovf_d = drop ? 1'b1 : (i_ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is data only; validity is carried entirely by count_q.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= enc_payload;
  end

  assign o_data_encoded = empty ? 64'd0 : mem_q[rd_ptr_q];
  assign o_d_valid      = !empty;
  assign o_level        = count_q;
  assign o_overflow     = ovf_q;

`ifdef SB_ENC_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [7:0] drop_base;

  always_comb begin
    drop_base  = i_ovf_clr ? 8'd0 : drop_cnt_q;
    drop_cnt_d = drop ? sat_inc8(drop_base) : drop_base;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) drop_cnt_q <= 8'd0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: doc/sb_data_encoder_fifo.md
Name: sb_data_encoder_fifo

Overview:
- Parametrised successor to the sideband TX data encoder.
- Maps a state/sub-state/message-number context plus a raw data bus onto a 64-bit sideband payload.
- Buffers encoded payloads in a FIFO with a valid/ready handshake toward packet framing, so that framing backpressure never loses payloads silently.
- Adds a generic data width, configurable buffer depth, a flush, and sticky overflow reporting.

Parameters:
- DATA_W, 16, raw data bus width; legal range 16..64.
- PARAM_W, 11, width of the MBINIT.PARAM capability field taken from the data bus; must be ≤ DATA_W.
- FIFO_DEPTH, 4, payload entries; power of 2, ≥ 2.
- MSG_NO_W, 4, message-number width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset. One clock; reset is asynchronous and active-high.
- i_msg_valid  in  1  a message request is present this cycle (single-cycle strobe).
- i_data_valid  in  1  i_data_bus carries data for this message.
- i_state  in  4  LTSM state (MBINIT = 3).
- i_sub_state  in  4  sub-state (PARAM = 0, REVERSALMB = 4).
- i_msg_no  in  MSG_NO_W  message number; 0 = idle.
- i_data_bus  in  DATA_W  raw data.
- i_test_en  in  1  point-test/eye-sweep mode active.
- i_test_mode  in  2  0 TX_POINT, 1 TX_EYE, 2 RX_POINT, 3 RX_EYE.
- i_flush  in  1  synchronous FIFO clear.
- i_ovf_clr  in  1  clears o_overflow.
- i_ready  in  1  packet framing accepts the head payload.
- o_data_encoded  out  64  head payload (zero when empty).
- o_d_valid  out  1  FIFO non-empty.
- o_level  out  $clog2(FIFO_DEPTH)+1  occupancy.
- o_overflow  out  1  sticky; set when a payload was dropped.

Behaviour:
- Reset: FIFO empty, o_d_valid = 0, o_data_encoded = 0, o_level = 0, o_overflow = 0. Reset asserted mid-operation discards all entries immediately.
- Encoding is combinational from inputs sampled at edge N and produces "push" plus "payload":
  - i_msg_valid = 0: no push.
  - i_msg_valid = 1 and i_data_valid = 0: push all-zero payload (no-data message).
  - i_test_en = 1, i_data_valid = 1, i_msg_no = 1, any mode: push setup payload. Bit0 = d[0]; bits7:6 = d[2:1]; bit11 = d[3]; bits58:43 = all ones; bit59 = d[4]; all other bits 0.
  - i_test_en = 1, i_data_valid = 1, other message numbers: push the zero-extended data bus when (mode 0 or 2, msg_no = 6) or (mode 3, msg_no = 9); otherwise push zero. Mode 1 always pushes zero.
  - i_test_en = 0, i_data_valid = 1, msg_no = 0: no push.
  - i_test_en = 0, i_data_valid = 1, MBINIT/PARAM: push zero-extended d[PARAM_W-1:0].
  - i_test_en = 0, i_data_valid = 1, MBINIT/REVERSALMB, msg_no = 6: push zero-extended d[DATA_W-1:0].
  - i_test_en = 0, i_data_valid = 1, any other state/sub-state/message: no push.
- Zero extension: payload[63:DATA_W] = 0.
- FIFO:
  - Pop = o_d_valid & i_ready.
  - Push is accepted when not full, or when full with a pop in the same cycle.
  - Push and pop in the same cycle when empty: payload is written; o_d_valid rises next cycle (no bypass).
  - Latency from encoded input to o_d_valid is 1 cycle when empty.
  - Pointers wrap modulo FIFO_DEPTH; order is strictly FIFO.
  - o_data_encoded is driven from the head entry, registered and stable while o_d_valid & ~i_ready.
- Overflow:
  - A push while full without a pop drops the new payload; FIFO contents are unchanged; o_overflow is set next cycle.
  - i_ovf_clr clears o_overflow; a set in the same cycle as a clear wins.
- Flush: i_flush empties the FIFO next cycle. Flush has priority over push and pop in the same cycle; a pushed payload is discarded without setting overflow. o_overflow is unaffected by flush.
- o_level tracks occupancy: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.

Optional Feature:
- Macro SB_ENC_DROP_CNT_EN.
- Defined: adds output o_drop_cnt [7:0], a saturating count of dropped payloads (holds at 255). It resets to 0, is cleared by i_ovf_clr (an increment in the same cycle wins, giving 1), and is unaffected by flush.
- Undefined: port and counter absent; all other behaviour is identical.

Test Plan:
- MBINIT/PARAM, d = 16'hFFFF, msg_no = 2, i_ready = 1 → next cycle o_d_valid = 1, o_data_encoded = 64'h7FF; the following cycle o_d_valid = 0.
- i_test_en = 1, msg_no = 1, d = 16'h001F → payload 64'h0FFF_F800_0000_08C1. Then mode 3, msg_no = 9, d = 16'hA5A5 → 64'hA5A5.
- i_ready = 0, 5 consecutive pushes with FIFO_DEPTH = 4 → o_level = 4, o_overflow = 1, 5th payload lost; raising i_ready drains the 4 payloads in order.
- FIFO full, push with simultaneous pop → accepted, o_level stays 4, o_overflow stays 0.
- FIFO holding 3 entries, i_flush with a concurrent push → o_level = 0 next cycle, o_d_valid = 0, o_overflow unchanged.
- Assert i_rst mid-drain with 2 entries → o_d_valid and o_data_encoded go to 0 immediately; after release the FIFO is empty.
